// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU control unit.
// Opcodes, FSM states, write-back selects and decoded-control bundle.
package cpu_pkg;

  localparam int OPW  = 4;
  localparam int RW   = 3;
  localparam int IMMW = 8;
  localparam int PCW  = 8;

  typedef enum logic [OPW-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_LDI  = 4'h6,
    OP_IN   = 4'h7,
    OP_OUT  = 4'h8,
    OP_BEQ  = 4'h9,
    OP_JMP  = 4'hA,
    OP_HALT = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_IMM = 2'd1,
    WB_SW  = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic       rf;
    logic [1:0] wb_sel;
    logic       imm_sel;
    logic       out;
    logic       is_branch;
    logic       is_halt;
  } dec_t;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [RW-1:0]   rs;
    logic [RW-1:0]   rt;
    logic [RW-1:0]   rd;
    logic [IMMW-1:0] imm;
  } ir_t;

endpackage

// File: rtl/cpu_ctrl_if.sv
// Program ROM bus between the control unit and the async ROM.
// The controller drives the address; the ROM returns instruction fields.
interface cpu_ctrl_if;
  import cpu_pkg::*;

  logic [PCW-1:0]  Addr;
  logic [OPW-1:0]  DataOp;
  logic [RW-1:0]   Datars;
  logic [RW-1:0]   Datart;
  logic [RW-1:0]   Datard;
  logic [IMMW-1:0] Datai;

  modport master (
    output Addr,
    input  DataOp, Datars, Datart,
    input  Datard, Datai
  );

  modport slave (
    input  Addr,
    output DataOp, Datars, Datart,
    output Datard, Datai
  );
endinterface

// File: rtl/cpu_ctrl_op_decode.sv
// Combinational opcode decoder.
// Maps an opcode to write-back, operand and sequencing controls.
module op_decode
  import cpu_pkg::*;
(
  input  logic [OPW-1:0] op,
  output dec_t           dec
);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR}): begin
        dec.rf     = 1'b1;
        dec.wb_sel = WB_ALU;
      end
      (op == OP_ADDI): begin
        dec.rf      = 1'b1;
        dec.imm_sel = 1'b1;
        dec.wb_sel  = WB_ALU;
      end
      (op == OP_LDI): begin
        dec.rf     = 1'b1;
        dec.wb_sel = WB_IMM;
      end
      (op == OP_IN): begin
        dec.rf     = 1'b1;
        dec.wb_sel = WB_SW;
      end
      (op == OP_OUT):  dec.out       = 1'b1;
      (op inside {OP_BEQ, OP_JMP}):
        dec.is_branch = 1'b1;
      (op == OP_HALT): dec.is_halt   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit: PC, instruction register and
// FETCH/DECODE/EXEC/WB sequencing with datapath strobes.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter logic [PCW-1:0] RESET_PC = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  cpu_ctrl_if.master       rom,
  input  logic             alu_zero,
  output logic [PCW-1:0]   pc,
  output logic [OPW-1:0]   ir_op,
  output logic [RW-1:0]    ir_rs,
  output logic [RW-1:0]    ir_rt,
  output logic [RW-1:0]    ir_rd,
  output logic [IMMW-1:0]  ir_imm,
  output logic [OPW-1:0]   alu_op,
  output logic             imm_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             out_we,
  output logic             busy,
  output logic             halted
);

  state_e state, nxt;
  ir_t    ir;
  dec_t   dec;
  logic   br_taken;
  logic   in_ew;

  op_decode u_dec (
    .op  (ir.op),
    .dec (dec)
  );

  assign rom.Addr = pc;
  assign ir_op    = ir.op;
  assign ir_rs    = ir.rs;
  assign ir_rt    = ir.rt;
  assign ir_rd    = ir.rd;
  assign ir_imm   = ir.imm;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (run) nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = S_EXEC;
      S_EXEC:   nxt = dec.is_halt ? S_HALT : S_WB;
      S_WB:     nxt = run ? S_FETCH : S_IDLE;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      ir       <= '0;
      br_taken <= 1'b0;
    end else begin
      if (state == S_FETCH)
        ir <= {rom.DataOp, rom.Datars,
               rom.Datart, rom.Datard,
               rom.Datai};
      if (state == S_EXEC)
        br_taken <= dec.is_branch &
                    ((ir.op == OP_JMP) | alu_zero);
      if (state == S_WB)
        pc <= br_taken ? ir.imm : pc + 1'b1;
    end
  end

  // rst_n gates strobes so a reset during WB never half-commits
  always_comb begin
    in_ew   = (state == S_EXEC) || (state == S_WB);
    alu_op  = in_ew ? ir.op : '0;
    imm_sel = rst_n & in_ew & dec.imm_sel;
    rf_we   = rst_n & (state == S_WB) & dec.rf;
    out_we  = rst_n & (state == S_WB) & dec.out;
    wb_sel  = (rst_n && state == S_WB) ?
              dec.wb_sel : WB_ALU;
    busy    = (state != S_IDLE) &&
              (state != S_HALT);
    halted  = (state == S_HALT);
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed self-checking bench for cpu_ctrl.
// Bench models the async program ROM from a small table.
module tb_cpu_ctrl;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n, run, alu_zero;
  logic [7:0] pc, ir_imm, alu_op_w;
  logic [3:0] ir_op, alu_op;
  logic [2:0] ir_rs, ir_rt, ir_rd;
  logic imm_sel, rf_we, out_we, busy, halted;
  logic [1:0] wb_sel;
  logic [20:0] mem [256];
  logic [20:0] word;
  int checks = 0;
  int failures = 0;

  cpu_ctrl_if rom ();

  cpu_ctrl #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .rom(rom.master), .alu_zero(alu_zero),
    .pc(pc), .ir_op(ir_op), .ir_rs(ir_rs),
    .ir_rt(ir_rt), .ir_rd(ir_rd),
    .ir_imm(ir_imm), .alu_op(alu_op),
    .imm_sel(imm_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .out_we(out_we),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  always_comb begin
    word = mem[rom.Addr];
    rom.DataOp = word[20:17];
    rom.Datars = word[16:14];
    rom.Datart = word[13:11];
    rom.Datard = word[10:8];
    rom.Datai  = word[7:0];
  end

  assign alu_op_w = {4'h0, alu_op};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; alu_zero = 1'b0;
    tick(); tick();
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc got %0h exp 0", pc); end
    checks++; if (rom.Addr !== 8'h00) begin failures++; $display("FAIL reset_addr got %0h exp 0", rom.Addr); end
    checks++; if ({busy, halted} !== 2'b00) begin failures++; $display("FAIL reset_status got %b exp 00", {busy, halted}); end
    checks++; if ({rf_we, out_we, imm_sel} !== 3'b000) begin failures++; $display("FAIL reset_strobes got %b exp 000", {rf_we, out_we, imm_sel}); end
    checks++; if ({ir_op, ir_rd, ir_imm} !== 15'h0) begin failures++; $display("FAIL reset_ir got %0h exp 0", {ir_op, ir_rd, ir_imm}); end
  endtask

  task automatic test_ldi();
    rst_n = 1'b1; run = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ldi_fetch_busy got %b exp 1", busy); end
    tick();
    checks++; if ({ir_op, ir_rd, ir_imm} !== {4'h6, 3'd1, 8'h05}) begin failures++; $display("FAIL ldi_ir got %0h exp %0h", {ir_op, ir_rd, ir_imm}, {4'h6, 3'd1, 8'h05}); end
    tick();
    checks++; if ({alu_op, rf_we} !== {4'h6, 1'b0}) begin failures++; $display("FAIL ldi_exec got %0h exp %0h", {alu_op, rf_we}, {4'h6, 1'b0}); end
    tick();
    checks++; if ({rf_we, wb_sel, pc} !== {1'b1, 2'd1, 8'h00}) begin failures++; $display("FAIL ldi_wb got %0h exp %0h", {rf_we, wb_sel, pc}, {1'b1, 2'd1, 8'h00}); end
    tick();
    checks++; if ({rf_we, pc} !== {1'b0, 8'h01}) begin failures++; $display("FAIL ldi_next_pc got %0h exp %0h", {rf_we, pc}, {1'b0, 8'h01}); end
  endtask

  task automatic test_add();
    tick(); tick();
    checks++; if ({alu_op, imm_sel, rf_we} !== {4'h1, 2'b00}) begin failures++; $display("FAIL add_exec got %0h exp %0h", {alu_op, imm_sel, rf_we}, {4'h1, 2'b00}); end
    tick();
    checks++; if ({alu_op, rf_we, ir_rd, wb_sel} !== {4'h1, 1'b1, 3'd3, 2'd0}) begin failures++; $display("FAIL add_wb got %0h exp %0h", {alu_op, rf_we, ir_rd, wb_sel}, {4'h1, 1'b1, 3'd3, 2'd0}); end
    tick();
    checks++; if (pc !== 8'h02) begin failures++; $display("FAIL add_pc got %0h exp 2", pc); end
  endtask

  task automatic test_beq_taken();
    alu_zero = 1'b1;
    tick(); tick(); tick();
    checks++; if ({rf_we, out_we} !== 2'b00) begin failures++; $display("FAIL beq_wb_strobes got %b exp 00", {rf_we, out_we}); end
    tick();
    checks++; if (pc !== 8'h0A) begin failures++; $display("FAIL beq_taken_pc got %0h exp 0a", pc); end
  endtask

  task automatic test_jmp_wrap();
    tick(); tick(); tick(); tick();
    checks++; if (pc !== 8'hFF) begin failures++; $display("FAIL jmp_pc got %0h exp ff", pc); end
    tick(); tick(); tick();
    checks++; if ({rf_we, out_we, alu_op_w} !== 10'h0) begin failures++; $display("FAIL nop_wb got %0h exp 0", {rf_we, out_we, alu_op_w}); end
    tick();
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL wrap_pc got %0h exp 0", pc); end
  endtask

  task automatic test_run_drop();
    alu_zero = 1'b0;
    tick();
    run = 1'b0;
    tick(); tick();
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL drop_wb got %b exp 1", rf_we); end
    tick();
    checks++; if ({busy, pc} !== {1'b0, 8'h01}) begin failures++; $display("FAIL drop_idle got %0h exp %0h", {busy, pc}, {1'b0, 8'h01}); end
    tick();
    checks++; if ({busy, pc} !== {1'b0, 8'h01}) begin failures++; $display("FAIL drop_park got %0h exp %0h", {busy, pc}, {1'b0, 8'h01}); end
  endtask

  task automatic test_beq_not_taken();
    run = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    checks++; if (pc !== 8'h02) begin failures++; $display("FAIL resume_pc got %0h exp 2", pc); end
    tick(); tick(); tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL beq_nt_wb got %b exp 0", rf_we); end
    tick();
    checks++; if (pc !== 8'h03) begin failures++; $display("FAIL beq_nt_pc got %0h exp 3", pc); end
  endtask

  task automatic test_out();
    tick(); tick(); tick();
    checks++; if ({out_we, rf_we} !== 2'b10) begin failures++; $display("FAIL out_wb got %b exp 10", {out_we, rf_we}); end
    tick();
    checks++; if ({out_we, pc} !== {1'b0, 8'h04}) begin failures++; $display("FAIL out_pc got %0h exp %0h", {out_we, pc}, {1'b0, 8'h04}); end
  endtask

  task automatic test_halt();
    tick(); tick();
    checks++; if (alu_op !== 4'hF) begin failures++; $display("FAIL halt_exec got %0h exp f", alu_op); end
    tick();
    checks++; if ({halted, busy, rf_we, out_we, pc} !== {4'b1000, 8'h04}) begin failures++; $display("FAIL halt_state got %0h exp %0h", {halted, busy, rf_we, out_we, pc}, {4'b1000, 8'h04}); end
    tick(); tick();
    checks++; if ({halted, pc} !== {1'b1, 8'h04}) begin failures++; $display("FAIL halt_hold got %0h exp %0h", {halted, pc}, {1'b1, 8'h04}); end
    rst_n = 1'b0;
    tick();
    checks++; if ({halted, busy, pc} !== {2'b00, 8'h00}) begin failures++; $display("FAIL halt_reset got %0h exp 0", {halted, busy, pc}); end
    rst_n = 1'b1; run = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle got %b exp 0", busy); end
  endtask

  task automatic test_reset_wb();
    run = 1'b1;
    tick(); tick(); tick(); tick();
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL rwb_pre got %b exp 1", rf_we); end
    rst_n = 1'b0;
    #1;
    checks++; if ({rf_we, out_we} !== 2'b00) begin failures++; $display("FAIL rwb_gate got %b exp 00", {rf_we, out_we}); end
    tick();
    checks++; if ({busy, pc} !== {1'b0, 8'h00}) begin failures++; $display("FAIL rwb_after got %0h exp 0", {busy, pc}); end
    rst_n = 1'b1; run = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h00] = {4'h6, 3'd0, 3'd0, 3'd1, 8'h05};
    mem[8'h01] = {4'h1, 3'd1, 3'd2, 3'd3, 8'h00};
    mem[8'h02] = {4'h9, 3'd1, 3'd2, 3'd0, 8'h0A};
    mem[8'h03] = {4'h8, 3'd1, 3'd0, 3'd0, 8'h00};
    mem[8'h04] = {4'hF, 3'd0, 3'd0, 3'd0, 8'h00};
    mem[8'h0A] = {4'hA, 3'd0, 3'd0, 3'd0, 8'hFF};
    test_reset();
    test_ldi();
    test_add();
    test_beq_taken();
    test_jmp_wrap();
    test_run_drop();
    test_beq_not_taken();
    test_out();
    test_halt();
    test_reset_wb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
